// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM state encoding, the canonical NOP and the default reset PC.
// Pure declarations: no logic, no timing, no flow control.
package ifu_pkg;

    // Fetch FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        REQ      = 3'd0,
        WAIT     = 3'd1,
        HOLD     = 3'd2,
        WAIT_NPC = 3'd3,
        MISALIGN = 3'd4
    } ifu_state_e;

    // addi x0, x0, 0 -- substituted whenever the fetched word must not be executed.
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Architectural PC after reset.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // A fetch address is usable only if it is word aligned.
    function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one imem read per instruction, holds it for decode.
// Latency: dnpc accepted -> inst_valid after 3 cycles with a zero-wait memory (REQ, WAIT, HOLD).
// Backpressure: REQ waits for imem_req_ready, WAIT waits for the response, HOLD waits for inst_ready.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int                 WIDTH    = 32,
    parameter logic [WIDTH-1:0]   RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  dnpc_valid,
    input  logic [WIDTH-1:0]      dnpc,
    output logic [WIDTH-1:0]      pc,

    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [WIDTH-1:0]      imem_addr,
    input  logic                  imem_resp_valid,
    input  logic [31:0]           imem_resp_data,
    input  logic                  imem_resp_err,

    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [31:0]           inst,
    output logic [WIDTH-1:0]      inst_pc,
    output logic                  fetch_err
);

    ifu_state_e        state_q, state_d;
    logic [WIDTH-1:0]  pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic [WIDTH-1:0]  inst_pc_q, inst_pc_d;
    logic              err_q, err_d;

    // State and datapath registers; reset loads the boot PC and a harmless NOP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= REQ;
            pc_q      <= RESET_PC;
            inst_q    <= NOP_INST;
            inst_pc_q <= RESET_PC;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic. pc moves only when a dnpc is accepted in HOLD (with the
    // decode handshake) or in WAIT_NPC; a dnpc strobe in any other state is dropped.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        err_d     = err_q;

        unique case (state_q)
            REQ: begin
                if (imem_req_ready) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (imem_resp_valid) begin
                    inst_d    = imem_resp_err ? NOP_INST : imem_resp_data;
                    inst_pc_d = pc_q;
                    err_d     = imem_resp_err;
                    state_d   = HOLD;
                end
            end

            HOLD: begin
                if (inst_ready) begin
                    if (dnpc_valid) begin
                        // Fast path: next PC arrives together with the consume.
                        pc_d    = dnpc;
                        state_d = pc_misaligned(dnpc[1:0]) ? MISALIGN : REQ;
                    end else begin
                        state_d = WAIT_NPC;
                    end
                end
            end

            WAIT_NPC: begin
                if (dnpc_valid) begin
                    pc_d    = dnpc;
                    state_d = pc_misaligned(dnpc[1:0]) ? MISALIGN : REQ;
                end
            end

            MISALIGN: begin
                // No memory access for an unaligned PC; report a fault in its place.
                inst_d    = NOP_INST;
                inst_pc_d = pc_q;
                err_d     = 1'b1;
                state_d   = HOLD;
            end

            default: begin
                state_d = REQ;
            end
        endcase
    end

    // Outputs depend on registered state only.
    always_comb begin
        pc             = pc_q;
        imem_addr      = pc_q;
        imem_req_valid = (state_q == REQ);
        inst_valid     = (state_q == HOLD);
        inst           = inst_q;
        inst_pc        = inst_pc_q;
        fetch_err      = err_q;
    end

endmodule
